// File: rtl/dcm_pkg.sv
// ---------------------------------------------------------------------------
// dcm_pkg
// Shared constants and helpers for the programmable clock-enable generator.
//   PROG_W        : width of the clk_2 program value
//   CLK1_HALF_DEF : default clk_1 half-period in system clock cycles
//   h2Of()        : clk_2 half-period (in clk cycles) for a program value
// ---------------------------------------------------------------------------
package dcm_pkg;

    localparam int unsigned PROG_W        = 3;
    localparam int unsigned CLK1_HALF_DEF = 4;

    // clk_2 runs at clk_1's rate scaled down by (prog + 1), so its
    // half-period is that many clk_1 half-periods long.
    function automatic int unsigned h2Of(input logic [PROG_W-1:0] prog,
                                         input int unsigned       half);
        return half * (32'(prog) + 32'd1);
    endfunction

endpackage

// File: rtl/dcm_half_divider.sv
// ---------------------------------------------------------------------------
// dcm_half_divider
// Toggle divider: q flips every (limit + 1) clock cycles, giving a 50% duty
// square wave with half-period limit + 1.
// Ports:
//   clk     : system clock
//   rst     : synchronous active-high reset (counter and q cleared)
//   restart : synchronous phase restart, same effect as rst
//   limit   : terminal count, half-period minus one
//   q       : registered divided output
// ---------------------------------------------------------------------------
module dcm_half_divider #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic [CNT_W-1:0] limit,
    output logic             q
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_q;

    // Restart clears the count together with q, so a limit that shrinks
    // mid-count can never leave the counter stranded above the new limit.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_cnt <= '0;
            r_q   <= 1'b0;
        end else if (r_cnt == limit) begin
            r_cnt <= '0;
            r_q   <= ~r_q;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/dcm_clk_gen.sv
// ---------------------------------------------------------------------------
// dcm_clk_gen
// Generates a fixed-rate square wave (clk_1) and a programmable-rate square
// wave (clk_2) from the system clock. Both are registered data outputs, not
// clocks used inside this block.
// Ports:
//   clk      : system clock, everything on the rising edge
//   rst      : synchronous active-high reset, overrides update
//   update   : load strobe, captures prog_in and restarts clk_2 low
//   prog_in  : requested clk_2 divide setting
//   prog_out : currently active program value
//   clk_1    : clk / (2*CLK1_HALF), 50% duty
//   clk_2    : clk / (2*CLK1_HALF*(prog+1)), 50% duty
// ---------------------------------------------------------------------------
module dcm_clk_gen
    import dcm_pkg::*;
#(
    parameter int unsigned CLK1_HALF = CLK1_HALF_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              update,
    input  logic [PROG_W-1:0] prog_in,
    output logic [PROG_W-1:0] prog_out,
    output logic              clk_1,
    output logic              clk_2
);

    // Wide enough for the longest clk_2 half-period minus one (prog = 7).
    localparam int unsigned CNT_W = $clog2(8 * CLK1_HALF);

    logic [PROG_W-1:0] r_prog;
    logic [CNT_W-1:0]  w_limit1;
    logic [CNT_W-1:0]  w_limit2;

    // Program register. It updates on the same edge that restarts the clk_2
    // divider, so prog_out always matches the half-period in use.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prog <= '0;
        end else if (update) begin
            r_prog <= prog_in;
        end
    end

    assign w_limit1 = CNT_W'(CLK1_HALF - 1);
    assign w_limit2 = CNT_W'(h2Of(r_prog, CLK1_HALF) - 32'd1);

    dcm_half_divider #(
        .CNT_W (CNT_W)
    ) u_div1 (
        .clk     (clk),
        .rst     (rst),
        .restart (1'b0),
        .limit   (w_limit1),
        .q       (clk_1)
    );

    dcm_half_divider #(
        .CNT_W (CNT_W)
    ) u_div2 (
        .clk     (clk),
        .rst     (rst),
        .restart (update),
        .limit   (w_limit2),
        .q       (clk_2)
    );

    assign prog_out = r_prog;

endmodule

// File: tb/tb_dcm_clk_gen.sv
// ---------------------------------------------------------------------------
// tb_dcm_clk_gen
// Self-checking bench for dcm_clk_gen with CLK1_HALF = 4.
// ---------------------------------------------------------------------------
module tb_dcm_clk_gen;

    localparam int HALF = 4;

    logic       clk;
    logic       rst;
    logic       update;
    logic [2:0] prog_in;
    logic [2:0] prog_out;
    logic       clk_1;
    logic       clk_2;

    int checks = 0;
    int errors = 0;

    // Reference state: edges since reset release, edges since last clk_2
    // restart, the active program and its clk_2 half-period.
    int         edgeSinceRst = 0;
    int         edgeSinceUpd = 0;
    logic [2:0] modelProg    = 3'd0;
    int         modelH2      = HALF;

    typedef struct packed {
        logic       rst;
        logic       upd;
        logic [2:0] progIn;
        logic [2:0] expProg;
        logic       expC1;
        logic       expC2;
    } vec_t;

    vec_t vecs[18];

    dcm_clk_gen #(
        .CLK1_HALF (HALF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .update   (update),
        .prog_in  (prog_in),
        .prog_out (prog_out),
        .clk_1    (clk_1),
        .clk_2    (clk_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs away from the active edge, let the edge
    // happen, then advance the reference state to match.
    task automatic applyStimulus(input logic r, input logic u, input logic [2:0] p);
        @(negedge clk);
        rst     = r;
        update  = u;
        prog_in = p;
        @(posedge clk);
        #1;
        if (r) begin
            edgeSinceRst = 0;
            edgeSinceUpd = 0;
            modelProg    = 3'd0;
            modelH2      = HALF;
        end else begin
            edgeSinceRst++;
            if (u) begin
                modelProg    = p;
                modelH2      = HALF * (int'(p) + 1);
                edgeSinceUpd = 0;
            end else begin
                edgeSinceUpd++;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [2:0] expProg,
                               input logic expC1, input logic expC2);
        checks++;
        if (prog_out !== expProg) begin
            errors++;
            $display("[TB] FAIL %s prog_out: got %0d expected %0d", tag, prog_out, expProg);
        end
        checks++;
        if (clk_1 !== expC1) begin
            errors++;
            $display("[TB] FAIL %s clk_1: got %b expected %b", tag, clk_1, expC1);
        end
        checks++;
        if (clk_2 !== expC2) begin
            errors++;
            $display("[TB] FAIL %s clk_2: got %b expected %b", tag, clk_2, expC2);
        end
    endtask

    // Run n cycles with constant inputs, checking against the reference.
    task automatic runSeq(input string tag, input logic r, input logic u,
                          input logic [2:0] p, input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(r, u, p);
            checkOutput(tag, modelProg, 1'((edgeSinceRst / HALF) % 2),
                        1'((edgeSinceUpd / modelH2) % 2));
        end
    endtask

    initial begin
        rst     = 1'b1;
        update  = 1'b0;
        prog_in = 3'd0;

        // Hand-computed: reset, free run with prog 0, then load 2 and
        // offer prog_in = 5 without update (must be ignored).
        //            rst   upd   in    prog  c1    c2
        vecs[0]  = '{1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 3'd2, 3'd2, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 3'd5, 3'd2, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 3'd5, 3'd2, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 3'd5, 3'd2, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 3'd5, 3'd2, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 3'd5, 3'd2, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 3'd5, 3'd2, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 3'd5, 3'd2, 1'b0, 1'b0};

        $display("[TB] table vectors");
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].upd, vecs[i].progIn);
            checkOutput($sformatf("vec%0d", i), vecs[i].expProg,
                        vecs[i].expC1, vecs[i].expC2);
        end

        $display("[TB] prog 2 steady");
        runSeq("prog2_run", 1'b0, 1'b0, 3'd2, 60);

        $display("[TB] prog 3 then 7");
        runSeq("load3", 1'b0, 1'b1, 3'd3, 1);
        runSeq("prog3_run", 1'b0, 1'b0, 3'd3, 70);
        runSeq("load7", 1'b0, 1'b1, 3'd7, 1);
        runSeq("prog7_run", 1'b0, 1'b0, 3'd7, 140);

        $display("[TB] update held high");
        runSeq("hold7", 1'b0, 1'b1, 3'd7, 40);
        runSeq("after_hold", 1'b0, 1'b0, 3'd7, 40);

        $display("[TB] shrink to prog 0 mid-count");
        runSeq("load0", 1'b0, 1'b1, 3'd0, 1);
        runSeq("prog0_run", 1'b0, 1'b0, 3'd0, 20);

        $display("[TB] prog_in changes without update");
        runSeq("ignore5", 1'b0, 1'b0, 3'd5, 50);

        $display("[TB] reset against update");
        runSeq("load7b", 1'b0, 1'b1, 3'd7, 1);
        runSeq("prog7b_run", 1'b0, 1'b0, 3'd7, 37);
        applyStimulus(1'b1, 1'b1, 3'd7);
        checkOutput("rst_wins", 3'd0, 1'b0, 1'b0);
        runSeq("post_rst", 1'b0, 1'b0, 3'd7, 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
